// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler for the shared 8:1 bit-select mux: grants one requester
// at a time for a bounded burst and forwards its data bit over valid/ready.
//
// state | meaning
// IDLE  | no grant; arbitrate among req starting at ptr
// GRANT | sel/grant held; beats counted until burst limit or request drop
module mux_rr_scheduler #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] data_in,
    input  logic       out_ready,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       out_valid,
    output logic       out_data,
    output logic       busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         ptr;
    logic [2:0]         pick;
    logic               pick_vld;
    logic [CNT_W-1:0]   cnt;
    logic               beat;
    logic               last_beat;
    logic               release_burst;

    // Walk from the highest offset down so the offset nearest ptr wins.
    always_comb begin
        logic [2:0] idx;
        idx      = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    assign beat          = (state == GRANT) && req[sel] && out_ready;
    assign last_beat     = beat && (cnt == CNT_W'(MAX_BURST - 1));
    assign release_burst = (state == GRANT) && (!req[sel] || last_beat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld)      state_nxt = GRANT;
            GRANT:   if (release_burst) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == GRANT);
        out_valid = (state == GRANT) && req[sel];
        out_data  = out_valid && data_in[sel];
    end

    // Grant bookkeeping: sel/grant only change on entry to or exit from GRANT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel   <= '0;
            grant <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            if (state == IDLE) begin
                if (pick_vld) begin
                    sel   <= pick;
                    grant <= 8'(1) << pick;
                    cnt   <= '0;
                end
            end else if (release_burst) begin
                grant <= '0;
                ptr   <= sel + 3'd1;
                cnt   <= '0;
            end else if (beat) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: directed stimulus pushes expected beats into a
// queue, a negedge monitor pops and compares each accepted beat.
module tb_mux_rr_scheduler;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] data_in;
    logic       out_ready;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       out_valid;
    logic       out_data;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] exp_q[$];

    mux_rr_scheduler #(.MAX_BURST(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Inputs change just after posedge, so a beat seen here lands on the next posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_beat: sel=%0d data=%0b with no beat expected", sel, out_data);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                check("beat_sel_data", 32'({sel, out_data}), 32'(e));
            end
        end
    end

    logic [7:0] rr_bits;
    logic [5:0] bp_rdy;
    logic [5:0] bp_dat;

    initial begin
        rr_bits   = 8'b1001_0110;
        bp_rdy    = 6'b111001;
        bp_dat    = 6'b110011;
        rst_n     = 1'b0;
        req       = 8'hFF;
        data_in   = 8'h00;
        out_ready = 1'b0;

        // Reset held with all requests high
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'h00);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        rst_n   = 1'b1;
        data_in = rr_bits;
        tick;
        check("first_grant", 32'(grant), 32'h01);
        check("first_sel", 32'(sel), 32'd0);

        // Round-robin across all eight, 4 beats each, 1-cycle bubble
        for (int g = 0; g < 9; g++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back({3'(g % 8), rr_bits[g % 8]});
        out_ready = 1'b1;
        for (int g = 0; g < 9; g++) begin
            repeat (4) @(posedge clk);
            #1;
            check("rr_bubble_busy", 32'(busy), 32'd0);
            check("rr_bubble_grant", 32'(grant), 32'h00);
            if (g < 8) begin
                tick;
                check("rr_sel", 32'(sel), 32'((g + 1) % 8));
                check("rr_grant", 32'(grant), 32'(8'(1) << ((g + 1) % 8)));
            end else begin
                req = 8'h00;
            end
        end
        repeat (3) tick;
        check("rr_idle_busy", 32'(busy), 32'd0);
        check("rr_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure on requester 3 (ptr is now 1)
        req       = 8'h08;
        data_in   = 8'h00;
        out_ready = 1'b0;
        tick;
        check("bp_sel", 32'(sel), 32'd3);
        check("bp_grant", 32'(grant), 32'h08);
        exp_q.push_back({3'd3, 1'b1});
        exp_q.push_back({3'd3, 1'b0});
        exp_q.push_back({3'd3, 1'b1});
        exp_q.push_back({3'd3, 1'b1});
        for (int i = 0; i < 6; i++) begin
            out_ready  = bp_rdy[i];
            data_in[3] = bp_dat[i];
            #1;
            check("bp_live_data", 32'(out_data), 32'(bp_dat[i]));
            tick;
            check("bp_busy", 32'(busy), 32'(i < 5));
        end
        req       = 8'h00;
        out_ready = 1'b1;

        // Early drop by requester 5 after two beats
        req     = 8'h20;
        data_in = 8'h20;
        tick;
        check("drop_sel", 32'(sel), 32'd5);
        exp_q.push_back({3'd5, 1'b1});
        exp_q.push_back({3'd5, 1'b1});
        tick;
        tick;
        req = 8'h00;
        tick;
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_valid", 32'(out_valid), 32'd0);
        req     = 8'h21;
        data_in = 8'h01;
        tick;
        check("drop_wrap_sel", 32'(sel), 32'd0);
        check("drop_wrap_grant", 32'(grant), 32'h01);
        check("drop_wrap_data", 32'(out_data), 32'd1);
        req = 8'h00;
        tick;
        req = 8'h40;
        tick;
        check("to6_sel", 32'(sel), 32'd6);
        req = 8'h00;
        tick;

        // Wrap priority with ptr=7
        req     = 8'h81;
        data_in = 8'h80;
        tick;
        check("wrap_sel", 32'(sel), 32'd7);
        check("wrap_grant", 32'(grant), 32'h80);
        for (int b = 0; b < 4; b++) exp_q.push_back({3'd7, 1'b1});
        repeat (4) tick;
        check("wrap_release", 32'(busy), 32'd0);
        tick;
        check("wrap_next_sel", 32'(sel), 32'd0);
        check("wrap_next_grant", 32'(grant), 32'h01);
        req = 8'h00;
        tick;

        // Async reset during the second beat of requester 2 (ptr is 1)
        req     = 8'h04;
        data_in = 8'h04;
        tick;
        check("ar_sel", 32'(sel), 32'd2);
        exp_q.push_back({3'd2, 1'b1});
        tick;
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_grant", 32'(grant), 32'h00);
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_sel0", 32'(sel), 32'd0);
        req = 8'h05;
        tick;
        rst_n = 1'b1;
        tick;
        check("ar_restart_sel", 32'(sel), 32'd0);
        check("ar_restart_grant", 32'(grant), 32'h01);
        req       = 8'h00;
        out_ready = 1'b0;
        repeat (2) tick;
        check("end_busy", 32'(busy), 32'd0);
        check("end_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
